dmem_resp: RTL and testbench



---
 rtl/dmem_resp_pkg.sv | 11 +
 rtl/dmem_resp_lane_ext.sv | 27 ++
 rtl/dmem_resp.sv | 115 +++++++++++
 tb/tb_dmem_resp.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared data-memory access-type encodings.
// The CPU's DMType field uses these same codes.
package dmem_resp_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

endpackage

// File: rtl/dmem_resp_lane_ext.sv
// Load-lane selection and sign/zero extension.
// Misaligned addresses simply truncate to the lane boundary.
module dm_lane_ext
    import dmem_resp_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  dmtype,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[{addr, 3'b000} +: 8];
        w_half = addr[1] ? word[31:16] : word[15:0];
        case (dmtype)
            DM_HALF:   data = {{16{w_half[15]}}, w_half};
            DM_HALF_U: data = {16'h0000, w_half};
            DM_BYTE:   data = {{24{w_byte[7]}}, w_byte};
            DM_BYTE_U: data = {24'h000000, w_byte};
            default:   data = word;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// MEM-stage data memory: masked stores on the clock edge, combinational
// extended loads, sticky store-error tracking and a committed-store count.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_w,
    input  logic [31:0]   addr_in,
    input  logic [31:0]   wdata_in,
    input  logic [2:0]    dmtype_in,
    output logic [31:0]   rdata_out,
    input  logic [AW-1:0] dm_sel,
    output logic [31:0]   dm_data,
    output logic          err_misalign,
    output logic          err_range,
    output logic [31:0]   err_addr,
    output logic [31:0]   st_cnt
);

    logic [31:0] r_mem [DEPTH];
    logic        r_err_misalign;
    logic        r_err_range;
    logic [31:0] r_err_addr;
    logic [31:0] r_st_cnt;

    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic [31:0]   w_word;
    logic          w_aligned;
    logic [3:0]    w_mask;
    logic [31:0]   w_lanes;
    logic          w_commit;
    logic          w_bad;

    assign w_idx      = addr_in[AW+1:2];
    assign w_in_range = (addr_in[31:AW+2] == '0);
    assign w_word     = w_in_range ? r_mem[w_idx] : 32'h0;

    dm_lane_ext u_ext (
        .word   (w_word),
        .addr   (addr_in[1:0]),
        .dmtype (dmtype_in),
        .data   (rdata_out)
    );

    assign dm_data = r_mem[dm_sel];

    // Replicate the store data across lanes so the mask alone picks the target
    always_comb begin
        w_aligned = 1'b1;
        w_mask    = 4'b1111;
        w_lanes   = wdata_in;
        case (dmtype_in)
            DM_HALF, DM_HALF_U: begin
                w_aligned = ~addr_in[0];
                w_mask    = addr_in[1] ? 4'b1100 : 4'b0011;
                w_lanes   = {2{wdata_in[15:0]}};
            end
            DM_BYTE, DM_BYTE_U: begin
                w_aligned = 1'b1;
                w_mask    = 4'b0001 << addr_in[1:0];
                w_lanes   = {4{wdata_in[7:0]}};
            end
            default: begin
                w_aligned = (addr_in[1:0] == 2'b00);
                w_mask    = 4'b1111;
                w_lanes   = wdata_in;
            end
        endcase
    end

    assign w_commit = mem_w & w_aligned & w_in_range;
    assign w_bad    = mem_w & ~(w_aligned & w_in_range);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_err_misalign <= 1'b0;
            r_err_range    <= 1'b0;
            r_err_addr     <= '0;
            r_st_cnt       <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_commit && w_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
                end
            end
            if (w_commit) begin
                r_st_cnt <= r_st_cnt + 32'd1;
            end
            if (mem_w && !w_aligned) begin
                r_err_misalign <= 1'b1;
            end
            if (mem_w && !w_in_range) begin
                r_err_range <= 1'b1;
            end
            // Only the first faulting address since reset is kept
            if (w_bad && !r_err_misalign && !r_err_range) begin
                r_err_addr <= addr_in;
            end
        end
    end

    assign err_misalign = r_err_misalign;
    assign err_range    = r_err_range;
    assign err_addr     = r_err_addr;
    assign st_cnt       = r_st_cnt;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed table-driven bench for dmem_resp (DEPTH=128).
// Vectors hold hand-computed loads, raw words, counts and error state.
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    logic        clk;
    logic        reset;
    logic        mem_w;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [2:0]  dmtype_in;
    logic [31:0] rdata_out;
    logic [6:0]  dm_sel;
    logic [31:0] dm_data;
    logic        err_misalign;
    logic        err_range;
    logic [31:0] err_addr;
    logic [31:0] st_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_resp #(.DEPTH(128)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_w        (mem_w),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .dmtype_in    (dmtype_in),
        .rdata_out    (rdata_out),
        .dm_sel       (dm_sel),
        .dm_data      (dm_data),
        .err_misalign (err_misalign),
        .err_range    (err_range),
        .err_addr     (err_addr),
        .st_cnt       (st_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  dmt;
        logic [6:0]  sel;
        logic [31:0] rd;
        logic [31:0] dm;
        logic [31:0] cnt;
        logic        mis;
        logic        rng;
        logic [31:0] ea;
    } vec_t;

    vec_t v [17];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        v[0]  = '{1'b1, 32'h10,  32'h8070F0FF, DM_WORD,   7'd4,  32'h0,        32'h8070F0FF, 32'd1, 1'b0, 1'b0, 32'h0};
        v[1]  = '{1'b0, 32'h10,  32'h0,        DM_BYTE,   7'd4,  32'hFFFFFFFF, 32'h8070F0FF, 32'd1, 1'b0, 1'b0, 32'h0};
        v[2]  = '{1'b0, 32'h11,  32'h0,        DM_BYTE_U, 7'd4,  32'h000000F0, 32'h8070F0FF, 32'd1, 1'b0, 1'b0, 32'h0};
        v[3]  = '{1'b0, 32'h12,  32'h0,        DM_HALF,   7'd4,  32'hFFFF8070, 32'h8070F0FF, 32'd1, 1'b0, 1'b0, 32'h0};
        v[4]  = '{1'b0, 32'h12,  32'h0,        DM_HALF_U, 7'd4,  32'h00008070, 32'h8070F0FF, 32'd1, 1'b0, 1'b0, 32'h0};
        v[5]  = '{1'b0, 32'h10,  32'h0,        3'b111,    7'd4,  32'h8070F0FF, 32'h8070F0FF, 32'd1, 1'b0, 1'b0, 32'h0};
        v[6]  = '{1'b1, 32'h20,  32'h11223344, DM_WORD,   7'd8,  32'h0,        32'h11223344, 32'd2, 1'b0, 1'b0, 32'h0};
        v[7]  = '{1'b1, 32'h22,  32'hFFFFFFAB, DM_BYTE,   7'd8,  32'h00000022, 32'h11AB3344, 32'd3, 1'b0, 1'b0, 32'h0};
        v[8]  = '{1'b1, 32'h20,  32'h0000CDEF, DM_HALF,   7'd8,  32'h00003344, 32'h11ABCDEF, 32'd4, 1'b0, 1'b0, 32'h0};
        v[9]  = '{1'b1, 32'h31,  32'hDEADBEEF, DM_WORD,   7'd12, 32'h0,        32'h0,        32'd4, 1'b1, 1'b0, 32'h31};
        v[10] = '{1'b1, 32'h200, 32'h00000077, DM_BYTE,   7'd0,  32'h0,        32'h0,        32'd4, 1'b1, 1'b1, 32'h31};
        v[11] = '{1'b0, 32'h200, 32'h0,        DM_BYTE,   7'd0,  32'h0,        32'h0,        32'd4, 1'b1, 1'b1, 32'h31};
        v[12] = '{1'b1, 32'h13,  32'h0000BEEF, DM_HALF,   7'd4,  32'hFFFF8070, 32'h8070F0FF, 32'd4, 1'b1, 1'b1, 32'h31};
        v[13] = '{1'b1, 32'h40,  32'h5A5A5A5A, DM_WORD,   7'd16, 32'h0,        32'h5A5A5A5A, 32'd5, 1'b1, 1'b1, 32'h31};
        v[14] = '{1'b0, 32'h40,  32'h0,        DM_WORD,   7'd16, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'd5, 1'b1, 1'b1, 32'h31};
        v[15] = '{1'b1, 32'h43,  32'h00000080, DM_BYTE_U, 7'd16, 32'h0000005A, 32'h805A5A5A, 32'd6, 1'b1, 1'b1, 32'h31};
        v[16] = '{1'b0, 32'h43,  32'h0,        DM_BYTE,   7'd16, 32'hFFFFFF80, 32'h805A5A5A, 32'd6, 1'b1, 1'b1, 32'h31};

        reset     = 1'b1;
        mem_w     = 1'b0;
        addr_in   = 32'h10;
        wdata_in  = 32'h0;
        dmtype_in = DM_WORD;
        dm_sel    = 7'd4;

        // Reset alone, before any clock edge
        #1;
        check("rst_rdata", rdata_out, 32'h0);
        check("rst_dm", dm_data, 32'h0);
        check("rst_cnt", st_cnt, 32'h0);
        check("rst_mis", {31'h0, err_misalign}, 32'h0);
        check("rst_rng", {31'h0, err_range}, 32'h0);
        check("rst_ea", err_addr, 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            mem_w     = v[i].we;
            addr_in   = v[i].addr;
            wdata_in  = v[i].wd;
            dmtype_in = v[i].dmt;
            dm_sel    = v[i].sel;
            #1;
            check($sformatf("v%0d_rdata", i), rdata_out, v[i].rd);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_dm", i), dm_data, v[i].dm);
            check($sformatf("v%0d_cnt", i), st_cnt, v[i].cnt);
            check($sformatf("v%0d_mis", i), {31'h0, err_misalign}, {31'h0, v[i].mis});
            check($sformatf("v%0d_rng", i), {31'h0, err_range}, {31'h0, v[i].rng});
            check($sformatf("v%0d_ea", i), err_addr, v[i].ea);
        end

        // Same-cycle store and read: old word visible until the edge
        @(negedge clk);
        mem_w     = 1'b1;
        addr_in   = 32'h40;
        wdata_in  = 32'hA5A5A5A5;
        dmtype_in = DM_WORD;
        dm_sel    = 7'd16;
        #1;
        check("same_rdata_old", rdata_out, 32'h805A5A5A);
        check("same_dm_old", dm_data, 32'h805A5A5A);
        @(posedge clk);
        #1;
        check("same_rdata_new", rdata_out, 32'hA5A5A5A5);
        check("same_dm_new", dm_data, 32'hA5A5A5A5);
        check("same_cnt", st_cnt, 32'd7);

        // Async reset between edges while a store is pending
        @(negedge clk);
        mem_w    = 1'b1;
        addr_in  = 32'h40;
        wdata_in = 32'h12345678;
        #1;
        check("pre_rst_rdata", rdata_out, 32'hA5A5A5A5);
        #1;
        reset = 1'b1;
        #1;
        check("arst_rdata", rdata_out, 32'h0);
        check("arst_dm", dm_data, 32'h0);
        check("arst_cnt", st_cnt, 32'h0);
        check("arst_mis", {31'h0, err_misalign}, 32'h0);
        check("arst_rng", {31'h0, err_range}, 32'h0);
        check("arst_ea", err_addr, 32'h0);
        @(posedge clk);
        #1;
        check("arst_edge_dm", dm_data, 32'h0);
        @(negedge clk);
        mem_w = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_dm", dm_data, 32'h0);
        check("post_rst_cnt", st_cnt, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
